div_share_arb: RTL
==================

# div_share_arb

Round-robin scheduler that shares the single `div_fsm` long divider between up to NUM_REQ requesters, such as the frequency, period and duty-cycle calculations of the cymometer.

- Grants one requester at a time.
- Sequences the divider's `en`/`ready`/`vld_out` handshake.
- Traps divide-by-zero without using the divider.
- Aborts hung operations with a watchdog.
- Routes the result back to the owner with a one-cycle `done` pulse.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- DATAWIDTH, 57: operand/result width; matches `div_fsm`.
- TIMEOUT, 128: maximum cycles in WAIT before abort (must exceed divider latency).

Ports:
- sys_clk  in  1  system clock; the block's only clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_dividend  in  NUM_REQ*DATAWIDTH  packed dividends; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH].
- req_divisor  in  NUM_REQ*DATAWIDTH  packed divisors, same packing.
- ack  out  NUM_REQ  one-hot one-cycle pulse: operands accepted.
- done  out  NUM_REQ  one-hot one-cycle pulse: result valid.
- res_quotient  out  DATAWIDTH  result quotient; valid while `done` is nonzero, held until the next `done`.
- res_remainder  out  DATAWIDTH  result remainder; same timing as `res_quotient`.
- res_err  out  1  error flag (divide-by-zero or timeout); same timing as `res_quotient`.
- div_en  out  1  one-cycle start pulse to `div_fsm`.
- div_dividend  out  DATAWIDTH  operand to `div_fsm`; held stable from the `div_en` cycle until leaving WAIT.
- div_divisor  out  DATAWIDTH  operand to `div_fsm`; same timing as `div_dividend`.
- div_ready  in  1  divider idle and able to accept `en`.
- div_quotient  in  DATAWIDTH  divider quotient; valid in the `div_vld` cycle.
- div_remainder  in  DATAWIDTH  divider remainder; valid in the `div_vld` cycle.
- div_vld  in  1  one-cycle pulse from the divider: result valid.

## Operation
State machine: IDLE, ISSUE, WAIT, DONE. All outputs are registered.

- IDLE:
  - Launch condition: `req` nonzero and `div_ready`=1.
  - Grant the first set `req` bit at or after rr_ptr, searching upward with wrap-around.
  - Latch the owner index and its operands; pulse `ack[owner]`.
  - If the latched divisor is 0: go to DONE with quotient = all ones, remainder = dividend, err = 1. `div_en` is never asserted.
  - Otherwise go to ISSUE.
  - If `div_ready`=0, stay in IDLE; requests wait.
- ISSUE:
  - `div_en`=1 for exactly this cycle, with the operands driven.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - On `div_vld`: latch quotient and remainder, err = 0; go to DONE.
  - Otherwise increment the watchdog. When it reaches TIMEOUT−1 without `div_vld`: quotient = 0, remainder = 0, err = 1; go to DONE.
- DONE:
  - `done[owner]`=1 and the result registers update for exactly this cycle.
  - rr_ptr ← (owner+1) mod NUM_REQ; go to IDLE.
- Requester protocol:
  - Hold `req[i]` and its operands until `ack[i]`.
  - A requester samples its result on `done[i]`.
  - `req` is sampled only in IDLE, so `req[i]` still high when IDLE is re-entered counts as a new request.
- `div_vld` arriving outside WAIT (a stale result after timeout) is ignored.
- A new issue always waits for `div_ready`=1, so a stale operation drains before the next launch.
- Async reset, including mid-operation:
  - State → IDLE, rr_ptr → 0, watchdog → 0.
  - `ack`, `done`, `div_en`, `res_err` → 0.
  - `res_quotient`, `res_remainder`, `div_dividend`, `div_divisor` → 0.
  - The interrupted operation is discarded; no `done` is produced for it.

## Timing
- Cycle 0: IDLE samples `req[i]`=1 with `div_ready`=1.
- Cycle 1: `ack[i]`=1 and `div_en`=1 (ISSUE).
- Cycles 2 onward: WAIT. If `div_vld` arrives in cycle k, `done[i]` and the result are at cycle k+1. IDLE is cycle k+2, and the earliest next `ack` is at cycle k+3.
- Divide-by-zero: `ack` at cycle 1, `done` at cycle 2, IDLE at cycle 3.
- Timeout:
  - Watchdog counts 0, 1, 2, … in successive WAIT cycles, starting in cycle 2.
  - With no `div_vld`, the last WAIT cycle is TIMEOUT+1.
  - `done` with err at cycle TIMEOUT+2.
- Simultaneous requests in one cycle: exactly one grant, chosen by rr_ptr. The losers keep `req` high and are served in later rounds in rotating order.
- `div_vld` in the same cycle the watchdog expires: the result wins, err = 0.

## Test plan
- Single request: req[0], 1000/7, divider model with 60-cycle latency. Required: `ack[0]` at cycle 1, one `div_en` pulse, `done[0]` with quotient 142, remainder 6, err 0.
- Divide-by-zero: req[1], 55/0. Required: `done[1]` at cycle 2, quotient all ones, remainder 55, err 1, `div_en` never asserted.
- Contention: req = 3'b111 held continuously from reset. Required: grant order 0, 1, 2, 0, 1, …; each `done` matches its owner's operands.
- Timeout: divider model never pulses `div_vld`, TIMEOUT=128. Required: `done` with err 1 and zero results at cycle 130; the next request is not issued until `div_ready`=1; a stale `div_vld` injected afterwards produces no `done`.
- Reset mid-WAIT: assert sys_rst_n=0 during cycle 20. Required: all outputs 0 immediately; no `done` for the aborted operation; after release, req[2] is granted before req[0] only if it is the first set bit from rr_ptr=0.
- Held req back-to-back: req[0] stays high continuously. Required: a new `ack[0]` at the cycle following each `done[0]` plus 2 (i.e., `done` at k+1, next `ack` at k+3), as long as no other request is pending.

Source files
------------

// File: rtl/div_share_arb.sv
// Round-robin scheduler that shares one long divider (div_fsm) between NUM_REQ requesters.
// Latency: ack 1 cycle after launch; done 1 cycle after div_vld (divide-by-zero: done 2 cycles after launch).
// Backpressure: launches only when div_ready=1; requests wait in IDLE; the watchdog aborts a hung divide.
//
// Ports:
//   sys_clk, sys_rst_n            clock, async active-low reset
//   req, req_dividend/divisor     per-requester request level and packed operands (i at [i*DATAWIDTH +: DATAWIDTH])
//   ack, done                     one-hot pulses: operands accepted / result valid
//   res_quotient/remainder/err    result of the last completed operation, held until the next done
//   div_en, div_dividend/divisor  start pulse and operands to the divider
//   div_ready, div_quotient/remainder, div_vld   divider status and result
module div_share_arb #(
    parameter int NUM_REQ   = 3,
    parameter int DATAWIDTH = 57,
    parameter int TIMEOUT   = 128
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_divisor,
    output logic [NUM_REQ-1:0]             ack,
    output logic [NUM_REQ-1:0]             done,
    output logic [DATAWIDTH-1:0]           res_quotient,
    output logic [DATAWIDTH-1:0]           res_remainder,
    output logic                           res_err,
    output logic                           div_en,
    output logic [DATAWIDTH-1:0]           div_dividend,
    output logic [DATAWIDTH-1:0]           div_divisor,
    input  logic                           div_ready,
    input  logic [DATAWIDTH-1:0]           div_quotient,
    input  logic [DATAWIDTH-1:0]           div_remainder,
    input  logic                           div_vld
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WDW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [IDXW-1:0]        rr_ptr_q;
    logic [IDXW-1:0]        owner_q;
    logic [WDW-1:0]         wd_q;
    logic [NUM_REQ-1:0]     ack_q;
    logic [NUM_REQ-1:0]     done_q;
    logic [DATAWIDTH-1:0]   res_quotient_q;
    logic [DATAWIDTH-1:0]   res_remainder_q;
    logic                   res_err_q;
    logic                   div_en_q;
    logic [DATAWIDTH-1:0]   div_dividend_q;
    logic [DATAWIDTH-1:0]   div_divisor_q;

    logic [IDXW-1:0]        grant_d;
    logic [NUM_REQ-1:0]     grant_oh_d;
    logic [NUM_REQ-1:0]     owner_oh;
    logic [IDXW-1:0]        rr_next;

    // Unpack the operand buses so the grant index selects directly.
    logic [DATAWIDTH-1:0]   dvd_arr [NUM_REQ];
    logic [DATAWIDTH-1:0]   dvs_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign dvd_arr[g] = req_dividend[g*DATAWIDTH +: DATAWIDTH];
        assign dvs_arr[g] = req_divisor[g*DATAWIDTH +: DATAWIDTH];
    end

    // Round-robin pick: first set req bit at or after rr_ptr_q, wrapping.
    // Scanning from the farthest offset down leaves the nearest hit in grant_d.
    always_comb begin
        logic [IDXW:0] idx;
        grant_d = rr_ptr_q;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + (IDXW+1)'(k);
            if (idx >= (IDXW+1)'(NUM_REQ)) begin
                idx = idx - (IDXW+1)'(NUM_REQ);
            end
            if (req[idx[IDXW-1:0]]) begin
                grant_d = idx[IDXW-1:0];
            end
        end
    end

    assign grant_oh_d = NUM_REQ'(1) << grant_d;
    assign owner_oh   = NUM_REQ'(1) << owner_q;
    assign rr_next    = (owner_q == IDXW'(NUM_REQ - 1)) ? '0 : owner_q + IDXW'(1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q         <= S_IDLE;
            rr_ptr_q        <= '0;
            owner_q         <= '0;
            wd_q            <= '0;
            ack_q           <= '0;
            done_q          <= '0;
            res_quotient_q  <= '0;
            res_remainder_q <= '0;
            res_err_q       <= 1'b0;
            div_en_q        <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
        end else begin
            // Pulse outputs default low; each is raised for one cycle below.
            ack_q    <= '0;
            done_q   <= '0;
            div_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if ((|req) && div_ready) begin
                        owner_q        <= grant_d;
                        ack_q          <= grant_oh_d;
                        div_dividend_q <= dvd_arr[grant_d];
                        div_divisor_q  <= dvs_arr[grant_d];
                        // A zero divisor never starts the divider.
                        div_en_q       <= (dvs_arr[grant_d] != '0);
                        state_q        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // This is the ack cycle; zero-divisor results are
                    // resolved here so done lands one cycle after ack.
                    wd_q <= '0;
                    if (div_divisor_q == '0) begin
                        res_quotient_q  <= '1;
                        res_remainder_q <= div_dividend_q;
                        res_err_q       <= 1'b1;
                        done_q          <= owner_oh;
                        state_q         <= S_DONE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A result in the expiry cycle still wins over the abort.
                    if (div_vld) begin
                        res_quotient_q  <= div_quotient;
                        res_remainder_q <= div_remainder;
                        res_err_q       <= 1'b0;
                        done_q          <= owner_oh;
                        state_q         <= S_DONE;
                    end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                        res_quotient_q  <= '0;
                        res_remainder_q <= '0;
                        res_err_q       <= 1'b1;
                        done_q          <= owner_oh;
                        state_q         <= S_DONE;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                S_DONE: begin
                    rr_ptr_q <= rr_next;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack           = ack_q;
    assign done          = done_q;
    assign res_quotient  = res_quotient_q;
    assign res_remainder = res_remainder_q;
    assign res_err       = res_err_q;
    assign div_en        = div_en_q;
    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;

endmodule
